// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Types and constants shared by the parametrised data memory and its response
// pipeline.
//   - memState_t : controller state (CLEAR zero-fills the array, RUN serves
//                  requests).
//   - BYTES / OFF_W / IDX_W : lane count, byte-offset width and word-index
//                  width of the default geometry (32-bit words, 256 deep).
//   - rspRec_t   : one response record {valid, fault, rdata} at the default
//                  width. Instances with another DATA_W declare a record of the
//                  same shape locally and hand it to the pipeline as a type
//                  parameter.
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 256;

    localparam int BYTES = DATA_W_DEF / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH_DEF);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } memState_t;

    typedef struct packed {
        logic                   valid;
        logic                   fault;
        logic [BYTES*8-1:0]     rdata;
    } rspRec_t;

endpackage : mem_pkg

// File: rtl/mem_rsp_pipe.sv
// -----------------------------------------------------------------------------
// mem_rsp_pipe
// Fixed-depth shift register of response records. A record entering on d
// appears on q exactly STAGES rising edges later. Reset clears every stage, so
// any response in flight is dropped the moment reset is asserted.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-low clear of all stages
//   d      in   record captured into the first stage every cycle
//   q      out  record leaving the last stage
// -----------------------------------------------------------------------------
module mem_rsp_pipe
    import mem_pkg::*;
#(
    parameter int  STAGES = 1,
    parameter type rec_t  = rspRec_t
) (
    input  logic clk,
    input  logic reset,
    input  rec_t d,
    output rec_t q
);

    rec_t stage [STAGES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule : mem_rsp_pipe

// File: rtl/param_data_memory.sv
// -----------------------------------------------------------------------------
// param_data_memory
// Word-organised data RAM with DATA_W/8 byte lanes, a valid/ready request port
// and a fixed-latency response path. After reset the controller zero-fills the
// array one word per cycle (DEPTH cycles) before it starts accepting requests.
//
// Requests that are misaligned, fall outside the array (checked on the full
// byte address) or carry an empty lane mask fault: they leave the array
// untouched and answer with rsp_fault=1, rsp_rdata=0.
//
// Timing: at the accept edge a write commits its enabled lanes and a read
// samples the array (masked by req_be). The response record is captured at
// that edge and then shifted through a READ_LAT-stage pipeline, so rsp_valid
// rises exactly READ_LAT edges after acceptance. One request per cycle, in
// order, no backpressure on responses.
//
// Parameters: DATA_W (multiple of 8, >= 16), DEPTH (power of two, >= 2),
//             ADDR_W (>= log2(DATA_W/8) + log2(DEPTH)), READ_LAT (1..4).
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   req_valid  in   request present
//   req_ready  out  request accepted this cycle if req_valid (RUN state only)
//   req_write  in   1 = write, 0 = read
//   req_addr   in   byte address
//   req_be     in   byte-lane enables
//   req_wdata  in   write data
//   rsp_valid  out  one-cycle response pulse
//   rsp_rdata  out  read data, disabled lanes zero, zero for writes/faults
//   rsp_fault  out  request faulted, qualified by rsp_valid
// -----------------------------------------------------------------------------
module param_data_memory
    import mem_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ADDR_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W/8-1:0]   req_be,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_fault
);

    localparam int LANE_N     = DATA_W / 8;
    localparam int LANE_OFF_W = $clog2(LANE_N);
    localparam int WORD_IDX_W = $clog2(DEPTH);
    localparam int HI_LSB     = LANE_OFF_W + WORD_IDX_W;

    // Same shape as mem_pkg::rspRec_t, sized for this instance's DATA_W.
    typedef struct packed {
        logic              valid;
        logic              fault;
        logic [DATA_W-1:0] rdata;
    } recW_t;

    // ------------------------------------------------------------------
    // Controller state
    // ------------------------------------------------------------------
    memState_t               state;
    memState_t               stateNext;
    logic [WORD_IDX_W-1:0]   clr_idx;
    logic [WORD_IDX_W-1:0]   clrIdxNext;

    logic [DATA_W-1:0]       mem [DEPTH];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                    accept;
    logic                    misaligned;
    logic                    outOfRange;
    logic                    emptyMask;
    logic                    reqFault;
    logic [WORD_IDX_W-1:0]   wordIdx;
    logic [DATA_W-1:0]       laneMask;

    recW_t                   sampleNext;
    recW_t                   sampleRec;
    recW_t                   pipeOut;

    assign req_ready  = (state == RUN);
    assign accept     = req_valid && req_ready;

    assign misaligned = |req_addr[LANE_OFF_W-1:0];
    assign wordIdx    = req_addr[LANE_OFF_W +: WORD_IDX_W];
    assign emptyMask  = (req_be == '0);

    // Any set bit above the word index means the word lies past DEPTH-1; the
    // upper bits are tested directly so a large address never aliases onto a
    // low word.
    generate
        if (ADDR_W > HI_LSB) begin : gRangeCheck
            assign outOfRange = |req_addr[ADDR_W-1:HI_LSB];
        end else begin : gNoRangeCheck
            assign outOfRange = 1'b0;
        end
    endgenerate

    assign reqFault = misaligned || outOfRange || emptyMask;

    always_comb begin
        laneMask = '0;
        for (int l = 0; l < LANE_N; l++) begin
            laneMask[8*l +: 8] = {8{req_be[l]}};
        end
    end

    // Response record for the request being accepted this cycle. Writes and
    // faulted requests answer with zero data.
    always_comb begin
        sampleNext = '0;
        if (accept) begin
            sampleNext.valid = 1'b1;
            sampleNext.fault = reqFault;
            if (!reqFault && !req_write) begin
                sampleNext.rdata = mem[wordIdx] & laneMask;
            end
        end
    end

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the values from before the edge, independent of the order
    // in which the simulator evaluates always blocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= stateNext;
            clr_idx <= clrIdxNext;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        stateNext  = state;
        clrIdxNext = clr_idx;
        unique case (state)
            CLEAR: begin
                // Wraps to 0 after the last word, leaving clr_idx ready for
                // the next clear.
                clrIdxNext = clr_idx + WORD_IDX_W'(1);
                if (clr_idx == WORD_IDX_W'(DEPTH - 1)) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                stateNext = RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------
    // NOTE: the array has no reset branch; it is zeroed by the CLEAR sweep,
    // which keeps it mappable onto RAM macros instead of resettable flops.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (accept && req_write && !reqFault) begin
            for (int l = 0; l < LANE_N; l++) begin
                if (req_be[l]) begin
                    mem[wordIdx][8*l +: 8] <= req_wdata[8*l +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response path: capture at the accept edge, then READ_LAT stages.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sampleRec <= '0;
        end else begin
            sampleRec <= sampleNext;
        end
    end

    mem_rsp_pipe #(
        .STAGES (READ_LAT),
        .rec_t  (recW_t)
    ) uRspPipe (
        .clk   (clk),
        .reset (reset),
        .d     (sampleRec),
        .q     (pipeOut)
    );

    assign rsp_valid = pipeOut.valid;
    assign rsp_fault = pipeOut.fault;
    assign rsp_rdata = pipeOut.rdata;

endmodule : param_data_memory

// File: tb/tb_param_data_memory.sv
// -----------------------------------------------------------------------------
// tb_param_data_memory
// Three instances (READ_LAT = 1, 3, 4) share one request stream. The stimulus
// side keeps a byte-addressed reference memory, decides fault/data for each
// request from the address rules and appends the expectation (with its accept
// cycle) to a list. A monitor walks that list independently per instance and
// checks data, fault and arrival cycle whenever rsp_valid is seen.
// -----------------------------------------------------------------------------
module tb_param_data_memory;

    localparam int NDUT  = 3;
    localparam int DEPTH = 256;

    logic              clk = 1'b0;
    logic              rstN;
    logic              reqValid;
    logic              reqWrite;
    logic [31:0]       reqAddr;
    logic [3:0]        reqBe;
    logic [31:0]       reqWdata;
    logic [NDUT-1:0]   reqReady;
    logic [NDUT-1:0]   rspValid;
    logic [NDUT-1:0]   rspFault;
    logic [31:0]       rspRdata [NDUT];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    int opId  = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          acc;
        int          id;
        logic [31:0] addr;
    } exp_t;

    exp_t        expList[$];
    int          rdPtr [NDUT] = '{default: 0};
    logic [7:0]  model [1024];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int latOf(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        param_data_memory #(
            .DATA_W   (32),
            .DEPTH    (DEPTH),
            .ADDR_W   (32),
            .READ_LAT (LAT)
        ) dut (
            .clk       (clk),
            .reset     (rstN),
            .req_valid (reqValid),
            .req_ready (reqReady[g]),
            .req_write (reqWrite),
            .req_addr  (reqAddr),
            .req_be    (reqBe),
            .req_wdata (reqWdata),
            .rsp_valid (rspValid[g]),
            .rsp_rdata (rspRdata[g]),
            .rsp_fault (rspFault[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: one expectation list, an independent read pointer per DUT.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < NDUT; g++) begin
            if (rspValid[g] === 1'b1) begin
                total++;
                if (rdPtr[g] >= expList.size()) begin
                    bad++;
                    $display("FAIL unexpected_rsp dut%0d cyc=%0d: got rdata=%h fault=%b, required no response",
                             g, cyc, rspRdata[g], rspFault[g]);
                end else begin
                    e = expList[rdPtr[g]];
                    rdPtr[g]++;
                    if (rspRdata[g] !== e.rdata || rspFault[g] !== e.fault || cyc != e.acc + latOf(g)) begin
                        bad++;
                        $display("FAIL rsp dut%0d op%0d addr=%h: got rdata=%h fault=%b cyc=%0d, required rdata=%h fault=%b cyc=%0d",
                                 g, e.id, e.addr, rspRdata[g], rspFault[g], cyc,
                                 e.rdata, e.fault, e.acc + latOf(g));
                    end
                end
            end else if (rstN && rdPtr[g] < expList.size() &&
                         expList[rdPtr[g]].acc + latOf(g) < cyc) begin
                total++;
                bad++;
                e = expList[rdPtr[g]];
                $display("FAIL missing_rsp dut%0d op%0d addr=%h: got no response by cyc=%0d, required one at cyc=%0d",
                         g, e.id, e.addr, cyc, e.acc + latOf(g));
                rdPtr[g]++;
            end
            // Responses still in flight when reset hits are dropped.
            if (!rstN) rdPtr[g] = expList.size();
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic modelClear();
        for (int i = 0; i < 1024; i++) model[i] = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reqValid = 1'b0;
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
        exp_t e;
        logic flt;
        @(negedge clk);
        total++;
        if (reqReady !== 3'b111) begin
            bad++;
            $display("FAIL ready_at_issue op%0d: got %b, required 111", opId, reqReady);
        end
        reqValid = 1'b1;
        reqWrite = wr;
        reqAddr  = addr;
        reqBe    = be;
        reqWdata = wdata;

        flt     = (addr % 4 != 0) || (addr >= 32'd1024) || (be == 4'h0);
        e.rdata = '0;
        e.fault = flt;
        e.acc   = cyc + 1;
        e.id    = opId;
        e.addr  = addr;
        opId++;
        if (!flt) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    if (wr) model[int'(addr) + i] = wdata[8*i +: 8];
                    else    e.rdata[8*i +: 8]    = model[int'(addr) + i];
                end
            end
        end
        expList.push_back(e);
    endtask

    task automatic checkQuiet(input string tag);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("%s_ready_dut%0d", tag, g), 32'(reqReady[g]), 32'd0);
            check($sformatf("%s_valid_dut%0d", tag, g), 32'(rspValid[g]), 32'd0);
            check($sformatf("%s_rdata_dut%0d", tag, g), rspRdata[g], 32'd0);
            check($sformatf("%s_fault_dut%0d", tag, g), 32'(rspFault[g]), 32'd0);
        end
    endtask

    // Counts edges from reset release until each DUT raises req_ready.
    task automatic waitClear(input string tag);
        int first [NDUT];
        bool_loop: for (int n = 1; n <= 600; n++) begin
            int done;
            @(negedge clk);
            done = 1;
            for (int g = 0; g < NDUT; g++) begin
                if (n == 1) first[g] = 0;
                if (reqReady[g] && first[g] == 0) first[g] = n;
                if (first[g] == 0) done = 0;
            end
            if (done != 0) begin
                reqValid = 1'b0;
                break;
            end
        end
        reqValid = 1'b0;
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("%s_clear_cycles_dut%0d", tag, g), 32'(first[g]), 32'(DEPTH));
        end
    endtask

    task automatic checkDrained(input string tag);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("%s_drained_dut%0d", tag, g), 32'(rdPtr[g]), 32'(expList.size()));
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] addr;
        int          r;

        rstN     = 1'b0;
        reqValid = 1'b0;
        reqWrite = 1'b0;
        reqAddr  = '0;
        reqBe    = '0;
        reqWdata = '0;
        modelClear();

        repeat (3) @(negedge clk);
        checkQuiet("reset");

        // A write held during CLEAR must be ignored, not queued.
        reqValid = 1'b1;
        reqWrite = 1'b1;
        reqAddr  = 32'h3FC;
        reqBe    = 4'hF;
        reqWdata = 32'hFFFF_FFFF;
        @(negedge clk);
        rstN = 1'b1;
        waitClear("first");

        // Boundary word after clear.
        issue(1'b0, 32'h3FC, 4'hF, 32'h0);
        idle(1);

        // Byte-lane merge.
        issue(1'b1, 32'h10, 4'hF, 32'h1122_3344);
        issue(1'b1, 32'h10, 4'h5, 32'hAABB_CCDD);
        issue(1'b0, 32'h10, 4'hF, 32'h0);
        idle(1);

        // Write then read on consecutive cycles.
        issue(1'b1, 32'h20, 4'hF, 32'hCAFE_F00D);
        issue(1'b0, 32'h20, 4'hF, 32'h0);
        idle(1);

        // Faults, each on its own, then proof the faulted write left 0x8 alone.
        issue(1'b1, 32'h8, 4'hF, 32'h5A5A_1234);
        idle(1);
        issue(1'b0, 32'h402, 4'hF, 32'h0);
        idle(1);
        issue(1'b0, 32'h400, 4'hF, 32'h0);
        idle(1);
        issue(1'b0, 32'h0001_0010, 4'hF, 32'h0);
        idle(1);
        issue(1'b1, 32'h8, 4'h0, 32'hFFFF_FFFF);
        idle(1);
        issue(1'b0, 32'h8, 4'hF, 32'h0);
        idle(1);

        // Masked read.
        issue(1'b0, 32'h10, 4'h6, 32'h0);
        idle(6);

        // Randomised traffic.
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 9);
            case (r)
                0:       addr = 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
                1:       addr = 32'(1024 + $urandom_range(0, 1023) * 4);
                2:       addr = ($urandom | 32'h0001_0000) & 32'hFFFF_FFFC;
                3:       addr = 32'($urandom_range(252, 255) * 4);
                default: addr = 32'($urandom_range(0, 15) * 4);
            endcase
            issue(1'($urandom_range(0, 1)), addr, 4'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        idle(8);
        checkDrained("random");

        // Reset with two reads in flight.
        issue(1'b0, 32'h10, 4'hF, 32'h0);
        issue(1'b0, 32'h20, 4'hF, 32'h0);
        idle(1);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checkQuiet("midreset");
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        modelClear();
        waitClear("second");
        idle(6);
        issue(1'b0, 32'h10, 4'hF, 32'h0);
        idle(8);
        checkDrained("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion by time limit, required finish");
        $fatal(1, "time limit");
    end

endmodule : tb_param_data_memory
